// File: rtl/aw_outstanding_ctrl.sv
// -----------------------------------------------------------------------------
// aw_outstanding_ctrl
//
// Write-channel controller that sits beside the AW ID extender. It throttles
// AW per original ID so that no ID ever has more than MAX_OUTSTANDING writes
// in flight, which keeps the extender's sequence numbers unambiguous. On the
// B channel it strips the sequence pad to restore the original BID, retires
// outstanding entries, and flags responses that return out of issue order or
// without a matching outstanding write.
//
// Ports
//   Aclk               clock, rising edge
//   ARESETnRst         asynchronous active-low reset
//   s_aw_id/valid/ready  upstream AW handshake (original ID)
//   m_aw_valid/ready     downstream AW handshake toward the extender
//   m_b_id/valid/ready   downstream B handshake, BID = {seq, orig_id}
//   s_b_id/valid/ready   upstream B handshake, BID restored to orig_id
//   err_clr            synchronous clear of order_err
//   order_err          sticky ordering / unexpected-response flag
//   outstanding_total  registered sum of all per-ID outstanding counts
//   busy               registered (outstanding_total != 0)
// -----------------------------------------------------------------------------
module aw_outstanding_ctrl #(
   parameter int ID_WIDTH        = 2,
   parameter int ID_PAD          = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                              Aclk,
   input  logic                                              ARESETnRst,
   input  logic [ID_WIDTH-1:0]                               s_aw_id,
   input  logic                                              s_aw_valid,
   output logic                                              s_aw_ready,
   output logic                                              m_aw_valid,
   input  logic                                              m_aw_ready,
   input  logic [ID_PAD+ID_WIDTH-1:0]                        m_b_id,
   input  logic                                              m_b_valid,
   output logic                                              m_b_ready,
   output logic [ID_WIDTH-1:0]                               s_b_id,
   output logic                                              s_b_valid,
   input  logic                                              s_b_ready,
   input  logic                                              err_clr,
   output logic                                              order_err,
   output logic [ID_WIDTH+$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_total,
   output logic                                              busy
);

   localparam int N  = 1 << ID_WIDTH;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = ID_WIDTH + CW;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

   // A limit above 2^ID_PAD would let two in-flight writes share a sequence
   // number, so such a configuration is rejected at elaboration.
   generate
      if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > (1 << ID_PAD)) begin : g_cfg_err
         $error("aw_outstanding_ctrl: MAX_OUTSTANDING must be in 1..2^ID_PAD");
      end
   endgenerate

   logic [CW-1:0]     cnt         [N];
   logic [CW-1:0]     cnt_nxt     [N];
   logic [ID_PAD-1:0] exp_seq     [N];
   logic [ID_PAD-1:0] exp_seq_nxt [N];
   logic [N-1:0]      inc;
   logic [N-1:0]      dec;
   logic [TW-1:0]     total_nxt;

   logic              stall;
   logic              aw_fire;
   logic              b_fire;
   logic              err_set;
   logic [ID_WIDTH-1:0] bid;
   logic [ID_PAD-1:0]   bseq;

   // AW path: purely combinational, no buffering
   assign stall      = (cnt[s_aw_id] == MAX_C);
   assign m_aw_valid = s_aw_valid & ~stall;
   assign s_aw_ready = m_aw_ready & ~stall;
   assign aw_fire    = s_aw_valid & s_aw_ready;

   // B path: pass-through with the sequence pad stripped, never stalled
   assign bid       = m_b_id[ID_WIDTH-1:0];
   assign bseq      = m_b_id[ID_PAD+ID_WIDTH-1:ID_WIDTH];
   assign s_b_id    = bid;
   assign s_b_valid = m_b_valid;
   assign m_b_ready = s_b_ready;
   assign b_fire    = m_b_valid & s_b_ready;

   assign err_set = b_fire & ((cnt[bid] == '0) | (bseq != exp_seq[bid]));

   always_comb begin
      total_nxt = '0;
      inc       = '0;
      dec       = '0;
      for (int i = 0; i < N; i++) begin
         inc[i] = aw_fire & (s_aw_id == ID_WIDTH'(i));
         dec[i] = b_fire & (bid == ID_WIDTH'(i)) & (cnt[i] != '0);

         cnt_nxt[i] = cnt[i];
         if (inc[i] && !dec[i])
            cnt_nxt[i] = cnt[i] + CW'(1);
         else if (dec[i] && !inc[i])
            cnt_nxt[i] = cnt[i] - CW'(1);

         // In order, bseq+1 equals exp_seq+1; otherwise this resyncs to the
         // observed sequence, so one assignment covers every case.
         exp_seq_nxt[i] = exp_seq[i];
         if (b_fire && (bid == ID_WIDTH'(i)))
            exp_seq_nxt[i] = bseq + ID_PAD'(1);

         total_nxt = total_nxt + TW'(cnt_nxt[i]);
      end
   end

   always_ff @(posedge Aclk or negedge ARESETnRst) begin
      if (!ARESETnRst) begin
         for (int i = 0; i < N; i++) begin
            cnt[i]     <= '0;
            exp_seq[i] <= '0;
         end
         order_err         <= 1'b0;
         outstanding_total <= '0;
         busy              <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            cnt[i]     <= cnt_nxt[i];
            exp_seq[i] <= exp_seq_nxt[i];
         end
         // Set beats clear when both happen on the same edge
         order_err         <= err_set | (order_err & ~err_clr);
         outstanding_total <= total_nxt;
         busy              <= (total_nxt != '0);
      end
   end

endmodule

// File: tb/tb_aw_outstanding_ctrl.sv
module tb_aw_outstanding_ctrl;

   logic       Aclk = 1'b0;
   logic       ARESETnRst = 1'b0;
   logic [1:0] s_aw_id = '0;
   logic       s_aw_valid = 1'b0;
   logic       s_aw_ready;
   logic       m_aw_valid;
   logic       m_aw_ready = 1'b1;
   logic [5:0] m_b_id = '0;
   logic       m_b_valid = 1'b0;
   logic       m_b_ready;
   logic [1:0] s_b_id;
   logic       s_b_valid;
   logic       s_b_ready = 1'b1;
   logic       err_clr = 1'b0;
   logic       order_err;
   logic [5:0] outstanding_total;
   logic       busy;

   aw_outstanding_ctrl #(.ID_WIDTH(2), .ID_PAD(4), .MAX_OUTSTANDING(8)) dut (
      .Aclk(Aclk), .ARESETnRst(ARESETnRst),
      .s_aw_id(s_aw_id), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
      .m_b_id(m_b_id), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
      .s_b_id(s_b_id), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
      .err_clr(err_clr), .order_err(order_err),
      .outstanding_total(outstanding_total), .busy(busy)
   );

   always #5 Aclk = ~Aclk;

   typedef struct {
      logic       awv;
      logic [1:0] awid;
      logic       awr;
      logic       bv;
      logic [5:0] bid;
      logic       br;
      logic       clr;
      logic       e_sawr;
      logic       e_mawv;
      logic       e_err;
      int         e_total;
   } vec_t;

   typedef struct {
      logic err;
      int   total;
      int   idx;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   nchk = 0;
   int   nerr = 0;

   function automatic vec_t mk(input logic awv, input logic [1:0] awid, input logic awr,
                               input logic bv, input logic [5:0] bid, input logic br,
                               input logic clr, input logic e_sawr, input logic e_mawv,
                               input logic e_err, input int e_total);
      vec_t v;
      v.awv = awv; v.awid = awid; v.awr = awr;
      v.bv = bv; v.bid = bid; v.br = br; v.clr = clr;
      v.e_sawr = e_sawr; v.e_mawv = e_mawv; v.e_err = e_err; v.e_total = e_total;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s [vec %0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   // Called just after a rising edge: drive, check combinational outputs
   // mid-cycle, then check registered outputs just after the next edge.
   task automatic step(input vec_t v, input int idx);
      exp_t e;
      s_aw_valid = v.awv; s_aw_id = v.awid; m_aw_ready = v.awr;
      m_b_valid = v.bv; m_b_id = v.bid; s_b_ready = v.br; err_clr = v.clr;
      #2;
      chk("s_aw_ready", idx, 32'(s_aw_ready), 32'(v.e_sawr));
      chk("m_aw_valid", idx, 32'(m_aw_valid), 32'(v.e_mawv));
      chk("s_b_valid", idx, 32'(s_b_valid), 32'(v.bv));
      chk("m_b_ready", idx, 32'(m_b_ready), 32'(v.br));
      chk("s_b_id", idx, 32'(s_b_id), 32'(v.bid[1:0]));
      e.err = v.e_err; e.total = v.e_total; e.idx = idx;
      sb.push_back(e);
      @(posedge Aclk);
      #1;
      e = sb.pop_front();
      chk("order_err", e.idx, 32'(order_err), 32'(e.err));
      chk("outstanding_total", e.idx, 32'(outstanding_total), 32'(e.total));
      chk("busy", e.idx, 32'(busy), 32'(e.total != 0));
   endtask

   task automatic idle_inputs();
      s_aw_valid = 1'b0; s_aw_id = '0; m_aw_ready = 1'b1;
      m_b_valid = 1'b0; m_b_id = '0; s_b_ready = 1'b1; err_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;

      // ID 2 fills to the limit, then stalls; other IDs are unaffected
      for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, 2, 1, 0, 6'h00, 1, 0, 1, 1, 0, k));
      tbl.push_back(mk(1, 2, 1, 0, 6'h00, 1, 0, 0, 0, 0, 8));
      tbl.push_back(mk(0, 2, 1, 0, 6'h00, 1, 0, 0, 0, 0, 8));
      tbl.push_back(mk(1, 1, 1, 0, 6'h00, 1, 0, 1, 1, 0, 9));
      // B seq 0 on ID 2 retires one entry and releases the stall
      tbl.push_back(mk(0, 0, 1, 1, 6'h02, 1, 0, 1, 0, 0, 8));
      tbl.push_back(mk(1, 2, 1, 0, 6'h00, 1, 0, 1, 1, 0, 9));
      // stalled again; B presented but not accepted upstream
      tbl.push_back(mk(1, 2, 1, 1, 6'h06, 0, 0, 0, 0, 0, 9));
      tbl.push_back(mk(0, 0, 1, 1, 6'h06, 1, 0, 1, 0, 0, 8));
      // three AWs on ID 0, then simultaneous AW and in-order B on ID 0
      for (int k = 9; k <= 11; k++) tbl.push_back(mk(1, 0, 1, 0, 6'h00, 1, 0, 1, 1, 0, k));
      tbl.push_back(mk(1, 0, 1, 1, 6'h00, 1, 0, 1, 1, 0, 11));
      // ID 1 now has seqs 0,1,2 in flight; seq 1 returns first
      tbl.push_back(mk(1, 1, 1, 0, 6'h00, 1, 0, 1, 1, 0, 12));
      tbl.push_back(mk(1, 1, 1, 0, 6'h00, 1, 0, 1, 1, 0, 13));
      tbl.push_back(mk(0, 0, 1, 1, 6'h05, 1, 0, 1, 0, 1, 12));
      // clear together with a new error: error wins
      tbl.push_back(mk(0, 0, 1, 1, 6'h01, 1, 1, 1, 0, 1, 11));
      tbl.push_back(mk(0, 0, 1, 0, 6'h00, 1, 1, 1, 0, 0, 11));
      tbl.push_back(mk(0, 0, 1, 0, 6'h00, 1, 0, 1, 0, 0, 11));
      // unexpected B on ID 3 (nothing outstanding)
      tbl.push_back(mk(0, 0, 1, 1, 6'h17, 1, 0, 1, 0, 1, 11));
      tbl.push_back(mk(0, 0, 1, 0, 6'h00, 1, 1, 1, 0, 0, 11));
      // downstream not ready: valid passes, nothing fires
      tbl.push_back(mk(1, 3, 0, 0, 6'h00, 1, 0, 0, 1, 0, 11));

      // reset state
      idle_inputs();
      ARESETnRst = 1'b0;
      #2;
      chk("rst m_aw_valid", -1, 32'(m_aw_valid), 32'd0);
      chk("rst s_b_valid", -1, 32'(s_b_valid), 32'd0);
      chk("rst total", -1, 32'(outstanding_total), 32'd0);
      chk("rst busy", -1, 32'(busy), 32'd0);
      chk("rst order_err", -1, 32'(order_err), 32'd0);
      @(posedge Aclk);
      #1;
      ARESETnRst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // async reset discards everything without a clock edge
      idle_inputs();
      #3;
      ARESETnRst = 1'b0;
      #1;
      chk("reset total", 200, 32'(outstanding_total), 32'd0);
      chk("reset busy", 200, 32'(busy), 32'd0);
      @(posedge Aclk);
      #1;
      ARESETnRst = 1'b1;

      // 20 in-order pairs on ID 0: seq 0..15 then wraps to 0..3
      idx = 300;
      for (int k = 0; k < 20; k++) begin
         step(mk(1, 0, 1, 0, 6'h00, 1, 0, 1, 1, 0, 1), idx++);
         step(mk(0, 0, 1, 1, 6'((k % 16) << 2), 1, 0, 1, 0, 0, 0), idx++);
      end
      // expected seq is now 4: seq 4 is clean, then seq 7 (expected 5) is not
      step(mk(1, 0, 1, 0, 6'h00, 1, 0, 1, 1, 0, 1), idx++);
      step(mk(0, 0, 1, 1, 6'h10, 1, 0, 1, 0, 0, 0), idx++);
      step(mk(1, 0, 1, 0, 6'h00, 1, 0, 1, 1, 0, 1), idx++);
      step(mk(0, 0, 1, 1, 6'h1C, 1, 0, 1, 0, 1, 0), idx++);

      // reset mid-burst with writes in flight and order_err set
      for (int k = 1; k <= 3; k++) step(mk(1, 0, 1, 0, 6'h00, 1, 0, 1, 1, 1, k), idx++);
      idle_inputs();
      #3;
      ARESETnRst = 1'b0;
      #1;
      chk("midburst total", idx, 32'(outstanding_total), 32'd0);
      chk("midburst busy", idx, 32'(busy), 32'd0);
      chk("midburst order_err", idx, 32'(order_err), 32'd0);
      @(posedge Aclk);
      #1;
      ARESETnRst = 1'b1;
      // a stale B after reset finds no outstanding entry
      step(mk(0, 0, 1, 1, 6'h08, 1, 0, 1, 0, 1, 0), idx++);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/aw_outstanding_ctrl.md
Name: aw_outstanding_ctrl

Overview:
- Write-channel controller sitting beside the AW ID extender in the AXI node.
- Throttles AW per original ID so that outstanding writes per ID never exceed MAX_OUTSTANDING, which keeps extended-ID sequence numbers unambiguous.
- On the B channel, strips the sequence pad to restore the original BID, retires outstanding entries, and checks that responses per ID return in issue order.

Parameters:
- ID_WIDTH, 2, original (slave-side) AXI ID width; number of tracked IDs N = 2^ID_WIDTH.
- ID_PAD, 4, sequence-pad width prepended above the original ID on the master side.
- MAX_OUTSTANDING, 8, per-ID outstanding limit. Legal range is 1 to 2^ID_PAD; values outside this range are a configuration error.

Ports:
- Aclk  in  1  clock; all state changes on rising edge.
- ARESETnRst  in  1  asynchronous active-low reset.
- s_aw_id  in  ID_WIDTH  original AW ID from upstream.
- s_aw_valid  in  1  upstream AW valid.
- s_aw_ready  out  1  AW ready to upstream.
- m_aw_valid  out  1  AW valid toward ID extender/downstream.
- m_aw_ready  in  1  downstream AW ready.
- m_b_id  in  ID_PAD+ID_WIDTH  extended BID, {seq, orig_id}.
- m_b_valid  in  1  downstream B valid.
- m_b_ready  out  1  B ready to downstream.
- s_b_id  out  ID_WIDTH  restored original BID.
- s_b_valid  out  1  B valid to upstream.
- s_b_ready  in  1  upstream B ready.
- err_clr  in  1  synchronous clear of order_err.
- order_err  out  1  sticky ordering/unexpected-response flag.
- outstanding_total  out  ID_WIDTH+clog2(MAX_OUTSTANDING+1)  sum of all per-ID counts.
- busy  out  1  outstanding_total != 0.

Behaviour:
- Reset, asynchronous, entered when ARESETnRst is low:
  - cnt[i] = 0 and exp_seq[i] = 0 for all i.
  - order_err = 0; outstanding_total = 0; busy = 0.
  - Handshake outputs follow their combinational equations, giving m_aw_valid = 0 and s_b_valid = 0 when inputs are idle.
- Per-ID state:
  - cnt[i] is clog2(MAX_OUTSTANDING+1) bits wide.
  - exp_seq[i] is ID_PAD bits wide and wraps mod 2^ID_PAD. Its reset value of 0 matches the extender's sequence reset.
- AW path, zero latency, combinational:
  - stall = (cnt[s_aw_id] == MAX_OUTSTANDING).
  - m_aw_valid = s_aw_valid & ~stall.
  - s_aw_ready = m_aw_ready & ~stall.
  - aw_fire = s_aw_valid & s_aw_ready.
  - While stalled, valid is held low downstream. The upstream must keep AW stable (AXI rule); the controller does not buffer.
- B path, zero latency:
  - s_b_id = m_b_id[ID_WIDTH-1:0]; s_b_valid = m_b_valid; m_b_ready = s_b_ready.
  - b_fire = m_b_valid & s_b_ready.
  - Let bid = m_b_id[ID_WIDTH-1:0] and bseq = m_b_id[ID_PAD+ID_WIDTH-1:ID_WIDTH].
- Counter update per edge, for each ID i:
  - inc = aw_fire & (s_aw_id == i).
  - dec = b_fire & (bid == i) & (cnt[i] != 0).
  - inc & dec: cnt unchanged. inc only: +1. dec only: -1.
  - No saturation is needed beyond the stall; cnt never exceeds MAX_OUTSTANDING.
- Ordering check on b_fire for ID bid:
  - cnt[bid] == 0 (unexpected response): set order_err. cnt stays 0; exp_seq[bid] <= bseq+1.
  - Else if bseq != exp_seq[bid]: set order_err, decrement cnt, and resync exp_seq[bid] <= bseq+1.
  - Else: exp_seq[bid] <= exp_seq[bid]+1.
  - Sequence wrap from 2^ID_PAD-1 to 0 is legal and not an error.
- B is never stalled by the controller; errors are flagged only.
- order_err: sticky. err_clr clears it next edge; if set and clear occur on the same edge, set wins.
- outstanding_total and busy: registered, and updated on the same edge as cnt. They equal the sum of the post-update counts.
- Reset mid-transaction: all counts and sequences are discarded. Any B arriving afterwards with cnt==0 sets order_err.

Test Plan:
1. After reset: s_aw_valid=1, s_aw_id=2, m_aw_ready=1 for 8 cycles -> 8 fires; cnt[2]=8, outstanding_total=8. 9th cycle -> s_aw_ready=0, m_aw_valid=0. AW on ID 1 in the same state -> passes.
2. From test 1, return B with m_b_id={4'd0,2'd2} -> s_b_id=2, cnt[2]=7, stall released next cycle, order_err=0.
3. Simultaneous AW fire on ID 0 and B fire on ID 0 with cnt[0]=3 -> cnt[0] remains 3, outstanding_total unchanged.
4. Issue 3 AWs on ID 1, return B seq 1 before seq 0 -> order_err=1 on that edge, exp_seq[1]=2, cnt[1]=2. Then assert err_clr together with a new error event -> order_err stays 1. err_clr alone -> order_err=0.
5. B with m_b_id={4'd5,2'd3} while cnt[3]=0 -> order_err=1, cnt[3]=0, s_b_valid passes through.
6. Sequence wrap: 20 in-order AW/B pairs on ID 0 (seq 0..15, then 0..3) -> no order_err; final exp_seq[0]=4. Assert ARESETnRst low mid-burst -> all counts 0 and busy=0 immediately.
